// File: rtl/ucie_rdi_tx_flit_packer.sv
`default_nettype none
//==============================================================================
// ucie_rdi_tx_flit_packer : packs MC beats into RDI flits, FIFO + RDI drive. Rev 1.0
//==============================================================================
module ucie_rdi_tx_flit_packer #(
    parameter int DW         = 120,
    parameter int BEATS      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    input  logic [DW-1:0]                   i_data,
    input  logic                            i_valid,
    input  logic                            i_last,
    output logic                            o_ready,
    output logic [BEATS*DW+23:0]            lp_data,
    output logic                            lp_valid,
    output logic                            lp_irdy,
    input  logic                            pl_trdy,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic [7:0]                      o_seq_num,
    output logic [15:0]                     o_flit_cnt
);

    localparam int FW   = BEATS * DW + 24;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HPAD = FW - BEATS * DW - 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slot_e;

    slot_e          slot_q, slot_d;
    logic [DW-1:0]  slot0_q, slot0_d, slot1_q, slot1_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [FW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [7:0]     seq_q, seq_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           ready_q, ready_d, valid_q, valid_d;

    logic           w_accept, w_tmo_hit, w_commit_tmo, w_commit_beat, w_push, w_pop;
    logic [1:0]     w_nb;
    logic [DW-1:0]  w_s0, w_s1, w_s2;
    logic [FW-1:0]  w_flit;

    assign w_accept      = i_valid && ready_q;
    assign w_tmo_hit     = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));
    assign w_commit_tmo  = w_tmo_hit && (slot_q != EMPTY) && (level_q < LW'(FIFO_DEPTH)) && !w_accept;
    assign w_commit_beat = w_accept && ((slot_q == TWO) || i_last);
    assign w_push        = w_commit_beat || w_commit_tmo;
    assign w_pop         = valid_q && pl_trdy;

    // The closing beat lands directly in its slot; only earlier beats come from the assembly regs.
    always_comb begin
        w_s0 = slot0_q;
        w_s1 = (slot_q == TWO) ? slot1_q : '0;
        w_s2 = '0;
        w_nb = 2'(slot_q);
        if (w_commit_beat) begin
            w_nb = 2'(slot_q) + 2'd1;
            case (slot_q)
                EMPTY:   w_s0 = i_data;
                ONE:     w_s1 = i_data;
                default: w_s2 = i_data;
            endcase
        end
        w_flit = {{HPAD{1'b0}}, seq_q, w_nb, w_s2, w_s1, w_s0};
    end

    always_comb begin
        slot_d   = slot_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        seq_d    = seq_q;
        tmo_d    = tmo_q;
        wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(w_push) - LW'(w_pop);
        cnt_d    = (w_pop && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

        if (w_push) begin
            slot_d = EMPTY;
            seq_d  = seq_q + 8'd1;
        end else if (w_accept) begin
            case (slot_q)
                EMPTY: begin
                    slot_d  = ONE;
                    slot0_d = i_data;
                end
                ONE: begin
                    slot_d  = TWO;
                    slot1_d = i_data;
                end
                default: slot_d = slot_q;
            endcase
        end

        if (w_accept || w_push || (slot_q == EMPTY)) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT)) begin
            tmo_d = tmo_q + TW'(1);
        end

        // Hold off beats in the cycle a timeout commit is due so the two never collide.
        ready_d = i_en && (level_d < LW'(FIFO_DEPTH)) &&
                  !((TIMEOUT != 0) && (tmo_d == TW'(TIMEOUT)) && (slot_d != EMPTY));
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= EMPTY;
            slot0_q  <= '0;
            slot1_q  <= '0;
            tmo_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            tmo_q    <= tmo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= w_flit;
        end
    end

    assign o_ready      = ready_q;
    assign lp_valid     = valid_q;
    assign lp_irdy      = valid_q;
    assign lp_data      = valid_q ? mem_q[rd_ptr_q] : '0;
    assign o_fifo_level = level_q;
    assign o_seq_num    = seq_q;
    assign o_flit_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ucie_rdi_tx_flit_packer.sv
`default_nettype none
//==============================================================================
// tb_ucie_rdi_tx_flit_packer : directed self-checking bench for the flit packer. Rev 1.0
//==============================================================================
module tb_ucie_rdi_tx_flit_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_en = 1'b0;
    logic [119:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         i_last = 1'b0;
    logic         o_ready;
    logic [383:0] lp_data;
    logic         lp_valid;
    logic         lp_irdy;
    logic         pl_trdy = 1'b0;
    logic [2:0]   o_fifo_level;
    logic [7:0]   o_seq_num;
    logic [15:0]  o_flit_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    ucie_rdi_tx_flit_packer #(
        .DW(120), .BEATS(3), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_ready(o_ready), .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_irdy(lp_irdy), .pl_trdy(pl_trdy), .o_fifo_level(o_fifo_level),
        .o_seq_num(o_seq_num), .o_flit_cnt(o_flit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [119:0] bt(input logic [7:0] n);
        return {n ^ 8'h5A, 104'h0123456789ABCDEF0123456789, n};
    endfunction

    function automatic logic [383:0] mkflit(input logic [1:0] nb, input logic [7:0] sq,
                                            input logic [119:0] a, input logic [119:0] b,
                                            input logic [119:0] c);
        return {14'h0, sq, nb, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one beat at a negedge and returns at the negedge after it is accepted.
    task automatic send(input logic [119:0] d, input logic last);
        int waited;
        waited  = 0;
        i_data  = d;
        i_last  = last;
        i_valid = 1'b1;
        while (!o_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!o_ready) chk("send_ready_timeout", {383'b0, o_ready}, 384'd1);
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    logic [383:0] exp_q [4];

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_ready",  {383'b0, o_ready},  384'd0);
        chk("rst_valid",  {383'b0, lp_valid}, 384'd0);
        chk("rst_irdy",   {383'b0, lp_irdy},  384'd0);
        chk("rst_data",   lp_data,            384'd0);
        chk("rst_level",  {381'b0, o_fifo_level}, 384'd0);
        chk("rst_seq",    {376'b0, o_seq_num},    384'd0);
        chk("rst_cnt",    {368'b0, o_flit_cnt},   384'd0);
        rst = 1'b0; i_en = 1'b1; pl_trdy = 1'b1;
        tick();
        chk("ready_after_en", {383'b0, o_ready}, 384'd1);

        // Three-beat flit
        send(bt(8'h01), 1'b0);
        send(bt(8'h02), 1'b0);
        chk("t1_no_valid_early", {383'b0, lp_valid}, 384'd0);
        send(bt(8'h03), 1'b0);
        chk("t1_valid", {383'b0, lp_valid}, 384'd1);
        chk("t1_irdy",  {383'b0, lp_irdy},  384'd1);
        chk("t1_flit",  lp_data, mkflit(2'd3, 8'd0, bt(8'h01), bt(8'h02), bt(8'h03)));
        chk("t1_seq",   {376'b0, o_seq_num}, 384'd1);
        tick();
        chk("t1_cnt",   {368'b0, o_flit_cnt}, 384'd1);
        chk("t1_drained", {383'b0, lp_valid}, 384'd0);

        // Single beat closed by last
        send(bt(8'h04), 1'b1);
        chk("t2_flit", lp_data, mkflit(2'd1, 8'd1, bt(8'h04), 120'd0, 120'd0));
        chk("t2_seq",  {376'b0, o_seq_num}, 384'd2);
        tick();
        chk("t2_cnt",  {368'b0, o_flit_cnt}, 384'd2);

        // Timeout closes a one-beat partial
        send(bt(8'h05), 1'b0);
        repeat (16) tick();
        chk("t3_not_yet",   {383'b0, lp_valid}, 384'd0);
        chk("t3_ready_low", {383'b0, o_ready},  384'd0);
        tick();
        chk("t3_tmo_valid", {383'b0, lp_valid}, 384'd1);
        chk("t3_tmo_flit",  lp_data, mkflit(2'd1, 8'd2, bt(8'h05), 120'd0, 120'd0));
        tick();

        // Second beat at idle cycle 10 restarts the timeout
        send(bt(8'h06), 1'b0);
        repeat (9) tick();
        send(bt(8'h07), 1'b0);
        repeat (16) tick();
        chk("t3_restart_not_yet", {383'b0, lp_valid}, 384'd0);
        tick();
        chk("t3_restart_flit", lp_data, mkflit(2'd2, 8'd3, bt(8'h06), bt(8'h07), 120'd0));
        tick();
        chk("t3_cnt", {368'b0, o_flit_cnt}, 384'd4);

        // Backpressure: fill the FIFO, then drain in order
        pl_trdy = 1'b0;
        for (int i = 0; i < 12; i++) send(bt(8'(8'h10 + i)), 1'b0);
        for (int k = 0; k < 4; k++)
            exp_q[k] = mkflit(2'd3, 8'(4 + k), bt(8'(8'h10 + 3*k)), bt(8'(8'h11 + 3*k)),
                              bt(8'(8'h12 + 3*k)));
        chk("t4_level_full", {381'b0, o_fifo_level}, 384'd4);
        chk("t4_ready_low",  {383'b0, o_ready},      384'd0);
        chk("t4_head",       lp_data, exp_q[0]);
        repeat (3) tick();
        chk("t4_head_stable", lp_data, exp_q[0]);
        chk("t4_still_full",  {381'b0, o_fifo_level}, 384'd4);
        pl_trdy = 1'b1;
        tick();
        chk("t4_ready_rise",  {383'b0, o_ready},      384'd1);
        chk("t4_level3",      {381'b0, o_fifo_level}, 384'd3);
        chk("t4_flit1",       lp_data, exp_q[1]);
        tick();
        chk("t4_flit2",       lp_data, exp_q[2]);
        tick();
        chk("t4_flit3",       lp_data, exp_q[3]);
        tick();
        chk("t4_empty",       {383'b0, lp_valid},     384'd0);
        chk("t4_cnt",         {368'b0, o_flit_cnt},   384'd8);

        // Disabled packer still closes a two-beat partial on timeout
        send(bt(8'h20), 1'b0);
        send(bt(8'h21), 1'b0);
        i_en = 1'b0;
        tick();
        chk("t5_ready_off", {383'b0, o_ready}, 384'd0);
        repeat (15) tick();
        chk("t5_not_yet",   {383'b0, lp_valid}, 384'd0);
        tick();
        chk("t5_flit", lp_data, mkflit(2'd2, 8'd8, bt(8'h20), bt(8'h21), 120'd0));
        tick();
        i_en = 1'b1;
        tick();

        // Sequence number wrap
        for (int i = 0; i < 246; i++) send(bt(8'(i)), 1'b1);
        chk("t6_seq255", {376'b0, o_seq_num}, 384'd255);
        send(bt(8'hEE), 1'b1);
        chk("t6_seq_wrap", {376'b0, o_seq_num}, 384'd0);
        chk("t6_flit255",  lp_data, mkflit(2'd1, 8'd255, bt(8'hEE), 120'd0, 120'd0));
        send(bt(8'hEF), 1'b1);
        chk("t6_flit0",    lp_data, mkflit(2'd1, 8'd0, bt(8'hEF), 120'd0, 120'd0));
        tick();
        chk("t6_cnt",      {368'b0, o_flit_cnt}, 384'd257);

        // Asynchronous reset with two queued flits and a partial beat
        pl_trdy = 1'b0;
        send(bt(8'h30), 1'b1);
        send(bt(8'h31), 1'b1);
        send(bt(8'h32), 1'b0);
        chk("t7_level2", {381'b0, o_fifo_level}, 384'd2);
        chk("t7_seq3",   {376'b0, o_seq_num},    384'd3);
        #2 rst = 1'b1;
        #1;
        chk("t7_async_valid", {383'b0, lp_valid},       384'd0);
        chk("t7_async_level", {381'b0, o_fifo_level},   384'd0);
        chk("t7_async_seq",   {376'b0, o_seq_num},      384'd0);
        chk("t7_async_data",  lp_data,                  384'd0);
        chk("t7_async_cnt",   {368'b0, o_flit_cnt},     384'd0);
        @(negedge clk);
        rst = 1'b0; pl_trdy = 1'b1;
        repeat (20) tick();
        chk("t7_partial_gone", {383'b0, lp_valid}, 384'd0);
        chk("t7_seq_still0",   {376'b0, o_seq_num}, 384'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
